// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared parameters, types and state encoding for the cache refill controller
package cache_pkg;
    localparam int K_DEF        = 12;
    localparam int SET_BITS_DEF = 4;
    localparam int WORDS_DEF    = 4;
    localparam int DW_DEF       = 32;

    typedef logic [1:0]       way_t;
    typedef logic [K_DEF-1:0] tag_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VICTIM,
        S_REQ,
        S_FILL,
        S_TAGWR,
        S_RESP
    } refill_state_t;
endpackage

// File: rtl/cache_refill_plru_tree.sv
// rtl/cache_refill_plru_tree.sv - per-set 3-bit tree pseudo-LRU state with victim lookup and update port
module plru_tree
    import cache_pkg::*;
#(
    parameter int SET_BITS = SET_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SET_BITS-1:0] rd_set,
    output way_t                victim,
    input  logic                upd_en,
    input  logic [SET_BITS-1:0] upd_set,
    input  way_t                upd_way
);
    localparam int SETS = 1 << SET_BITS;

    // bit 0 picks the pair, bit 1 picks within ways 0/1, bit 2 within ways 2/3
    logic [SETS-1:0][2:0] bits;
    logic [2:0]           cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits <= '0;
        end else if (upd_en) begin
            bits[upd_set][0] <= ~upd_way[1];
            if (!upd_way[1]) bits[upd_set][1] <= ~upd_way[0];
            else             bits[upd_set][2] <= ~upd_way[0];
        end
    end

    always_comb begin
        cur    = bits[rd_set];
        victim = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
    end
endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - lookup acceptance, victim selection, line refill and tag install for a 4-way cache
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int K        = K_DEF,
    parameter int SET_BITS = SET_BITS_DEF,
    parameter int WORDS    = WORDS_DEF,
    parameter int DW       = DW_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [K-1:0]               req_tag,
    input  logic [SET_BITS-1:0]        req_set,
    input  logic                       hit,
    input  way_t                       hit_way,
    input  logic [3:0]                 inv,
    output logic                       mem_req,
    output logic [K+SET_BITS-1:0]      mem_addr,
    input  logic                       mem_gnt,
    input  logic                       mem_rvalid,
    input  logic [DW-1:0]              mem_rdata,
    output logic                       data_we,
    output way_t                       data_way,
    output logic [SET_BITS-1:0]        data_set,
    output logic [$clog2(WORDS)-1:0]   data_word,
    output logic [DW-1:0]              data_wdata,
    output logic                       tag_we,
    output way_t                       tag_way,
    output logic [SET_BITS-1:0]        tag_set,
    output logic [K-1:0]               tag_wdata,
    output logic                       inv_wdata,
    output logic                       done,
    output logic                       done_hit,
    output way_t                       done_way
);
    localparam int WB = $clog2(WORDS);

    refill_state_t       state, state_nxt;
    logic [K-1:0]        tag_q;
    logic [SET_BITS-1:0] set_q;
    logic                hit_q;
    way_t                way_q;
    logic [3:0]          inv_q;
    logic [WB-1:0]       cnt_q;

    way_t                plru_victim, victim;
    logic                accept, last_beat, upd_en;
    way_t                upd_way;
    logic [SET_BITS-1:0] upd_set;

    assign accept    = (state == S_IDLE) && req_valid;
    assign last_beat = (state == S_FILL) && mem_rvalid && (cnt_q == WB'(WORDS - 1));

    // A hit refreshes PLRU at accept; a miss only once the tag is installed.
    assign upd_en  = (accept && hit) || (state == S_TAGWR);
    assign upd_set = (state == S_TAGWR) ? set_q : req_set;
    assign upd_way = (state == S_TAGWR) ? way_q : hit_way;

    plru_tree #(.SET_BITS(SET_BITS)) u_plru (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_set  (set_q),
        .victim  (plru_victim),
        .upd_en  (upd_en),
        .upd_set (upd_set),
        .upd_way (upd_way)
    );

    // Lowest-index invalid way wins over the PLRU choice.
    always_comb begin
        victim = plru_victim;
        for (int w = 3; w >= 0; w--) begin
            if (inv_q[w]) victim = way_t'(w);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_valid) state_nxt = hit ? S_RESP : S_VICTIM;
            S_VICTIM: state_nxt = S_REQ;
            S_REQ:    if (mem_gnt) state_nxt = S_FILL;
            S_FILL:   if (last_beat) state_nxt = S_TAGWR;
            S_TAGWR:  state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
            set_q <= '0;
            hit_q <= 1'b0;
            way_q <= '0;
            inv_q <= '0;
            cnt_q <= '0;
        end else begin
            if (accept) begin
                tag_q <= req_tag;
                set_q <= req_set;
                hit_q <= hit;
                way_q <= hit_way;
                inv_q <= inv;
            end
            if (state == S_VICTIM)            way_q <= victim;
            if ((state == S_REQ) && mem_gnt)  cnt_q <= '0;
            if ((state == S_FILL) && mem_rvalid) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign req_ready  = rst_n && (state == S_IDLE);
    assign mem_req    = (state == S_REQ);
    assign mem_addr   = {tag_q, set_q};
    assign data_we    = (state == S_FILL) && mem_rvalid;
    assign data_way   = way_q;
    assign data_set   = set_q;
    assign data_word  = cnt_q;
    assign data_wdata = mem_rdata;
    assign tag_we     = (state == S_TAGWR);
    assign tag_way    = way_q;
    assign tag_set    = set_q;
    assign tag_wdata  = tag_q;
    assign inv_wdata  = 1'b0;
    assign done       = (state == S_RESP);
    assign done_hit   = hit_q;
    assign done_way   = way_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - randomized self-checking bench for cache_refill_ctrl against a behavioural model
module tb_cache_refill_ctrl;
    localparam int K = 12, SB = 4, WORDS = 4, DW = 32;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_ready, hit = 1'b0;
    logic [K-1:0] req_tag = '0;
    logic [SB-1:0] req_set = '0;
    logic [1:0] hit_way = '0;
    logic [3:0] inv = '0;
    logic mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [K+SB-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0, data_wdata;
    logic data_we, tag_we, inv_wdata, done, done_hit;
    logic [1:0] data_way, tag_way, done_way, data_word;
    logic [SB-1:0] data_set, tag_set;
    logic [K-1:0] tag_wdata;

    cache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_set(req_set), .hit(hit), .hit_way(hit_way), .inv(inv),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .data_we(data_we), .data_way(data_way), .data_set(data_set),
        .data_word(data_word), .data_wdata(data_wdata), .tag_we(tag_we), .tag_way(tag_way),
        .tag_set(tag_set), .tag_wdata(tag_wdata), .inv_wdata(inv_wdata), .done(done),
        .done_hit(done_hit), .done_way(done_way)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // Reference PLRU: per set, which half is older and which way in each half is older.
    bit m_b0 [16], m_b1 [16], m_b2 [16];

    function automatic int model_victim(input int s, input logic [3:0] iv);
        for (int w = 0; w < 4; w++) if (iv[w]) return w;
        if (!m_b0[s]) return m_b1[s] ? 1 : 0;
        return m_b2[s] ? 3 : 2;
    endfunction

    function automatic void model_touch(input int s, input int w);
        m_b0[s] = (w < 2);
        if (w < 2) m_b1[s] = (w == 0);
        else       m_b2[s] = (w == 2);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 16; s++) begin m_b0[s] = 0; m_b1[s] = 0; m_b2[s] = 0; end
    endfunction

    int obs_cyc, obs_req_cycles, obs_beats, obs_tag_we, obs_tag_beats;
    bit obs_ready, obs_done, obs_done_hit, obs_addr_changed, obs_word_err, obs_data_err, obs_stray_we;
    logic [1:0] obs_done_way, obs_tag_way, obs_data_way;
    logic [SB-1:0] obs_tag_set, obs_data_set;
    logic [K-1:0] obs_tag_wdata;
    logic [K+SB-1:0] obs_addr;
    logic obs_inv_wdata;

    // Drives one lookup and plays the memory side; records what the DUT did.
    task automatic run_txn(input logic [K-1:0] t, input logic [SB-1:0] s, input logic h,
                           input logic [1:0] hw, input logic [3:0] iv, input int gnt_dly,
                           input int gap_pct, input bit stray, input int abort_at);
        int cyc, drv;
        bit granted;
        logic [1:0] exp_word;
        obs_req_cycles = 0; obs_beats = 0; obs_tag_we = 0; obs_tag_beats = -1;
        obs_done = 0; obs_addr_changed = 0; obs_word_err = 0; obs_data_err = 0; obs_stray_we = 0;
        obs_cyc = -1; obs_data_way = 'x; obs_data_set = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_tag = t; req_set = s; hit = h; hit_way = hw; inv = iv;
        obs_ready = req_ready;
        @(negedge clk);
        req_valid = 1'b0; hit = 1'b0;
        cyc = 1; drv = 0; granted = 0;
        while (cyc < 300) begin
            if (done) begin
                obs_done = 1; obs_cyc = cyc; obs_done_hit = done_hit; obs_done_way = done_way;
                break;
            end
            if (tag_we) begin
                obs_tag_we++; obs_tag_way = tag_way; obs_tag_set = tag_set;
                obs_tag_wdata = tag_wdata; obs_inv_wdata = inv_wdata; obs_tag_beats = obs_beats;
            end
            if (mem_req) begin
                if (obs_req_cycles == 0) obs_addr = mem_addr;
                else if (mem_addr !== obs_addr) obs_addr_changed = 1;
                obs_req_cycles++;
            end
            mem_gnt = mem_req && (obs_req_cycles > gnt_dly);
            mem_rvalid = 1'b0;
            exp_word = drv[1:0];
            if (mem_req && stray) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom;
            end else if (granted && drv < WORDS && $urandom_range(99) >= gap_pct) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom; drv++;
            end
            #1;
            if (data_we) begin
                if (!granted || !mem_rvalid) obs_stray_we = 1;
                if (data_word !== exp_word) obs_word_err = 1;
                if (data_wdata !== mem_rdata) obs_data_err = 1;
                obs_data_way = data_way; obs_data_set = data_set;
                obs_beats++;
            end
            if (mem_gnt) granted = 1;
            if (abort_at > 0 && obs_beats == abort_at) begin
                mem_gnt = 1'b0; mem_rvalid = 1'b1;
                rst_n = 1'b0;
                #1;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++; if ({mem_req, data_we, tag_we, done, done_hit} !== 5'b0) begin n_err++;
            $display("FAIL reset_strobes: got %b expected 00000", {mem_req, data_we, tag_we, done, done_hit}); end
        n_vec++; if ({mem_addr, done_way, inv_wdata, tag_wdata} !== '0) begin n_err++;
            $display("FAIL reset_fields: got addr=%h way=%0d tag=%h expected 0", mem_addr, done_way, tag_wdata); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_ready: got %b expected 1", req_ready); end
        model_reset();
    endtask

    task automatic test_hit();
        int ev;
        run_txn(12'h0A5, 4'd3, 1'b1, 2'd2, 4'b0000, 0, 0, 0, 0);
        model_touch(3, 2);
        n_vec++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL hit_ready: got %b expected 1", obs_ready); end
        n_vec++; if (obs_cyc != 1) begin n_err++; $display("FAIL hit_latency: got %0d expected 1", obs_cyc); end
        n_vec++; if ({obs_done_hit, obs_done_way} !== 3'b110) begin n_err++;
            $display("FAIL hit_resp: got hit=%b way=%0d expected hit=1 way=2", obs_done_hit, obs_done_way); end
        n_vec++; if (obs_req_cycles != 0 || obs_tag_we != 0 || obs_beats != 0) begin n_err++;
            $display("FAIL hit_no_refill: got req=%0d tagwe=%0d beats=%0d expected 0 0 0", obs_req_cycles, obs_tag_we, obs_beats); end
        ev = model_victim(3, 4'b0000);
        run_txn(12'h123, 4'd3, 1'b0, 2'd0, 4'b0000, 0, 0, 0, 0);
        model_touch(3, ev);
        n_vec++; if (int'(obs_done_way) != ev || int'(obs_tag_way) != ev) begin n_err++;
            $display("FAIL hit_plru_readback: got way=%0d expected %0d", obs_done_way, ev); end
    endtask

    task automatic test_cold_miss();
        logic [K-1:0] t;
        t = K'($urandom);
        run_txn(t, 4'd5, 1'b0, 2'd3, 4'b1111, 0, 0, 0, 0);
        model_touch(5, 0);
        n_vec++; if (obs_addr !== {t, 4'd5}) begin n_err++; $display("FAIL cold_addr: got %h expected %h", obs_addr, {t, 4'd5}); end
        n_vec++; if (obs_beats != WORDS || obs_word_err || obs_data_err) begin n_err++;
            $display("FAIL cold_beats: got beats=%0d worderr=%0d dataerr=%0d expected %0d 0 0", obs_beats, obs_word_err, obs_data_err, WORDS); end
        n_vec++; if (obs_data_way !== 2'd0 || obs_data_set !== 4'd5) begin n_err++;
            $display("FAIL cold_data_dest: got way=%0d set=%0d expected 0 5", obs_data_way, obs_data_set); end
        n_vec++; if (obs_tag_we != 1 || obs_tag_way !== 2'd0 || obs_tag_set !== 4'd5 || obs_tag_wdata !== t || obs_inv_wdata !== 1'b0) begin n_err++;
            $display("FAIL cold_tagwr: got n=%0d way=%0d set=%0d tag=%h inv=%b expected 1 0 5 %h 0", obs_tag_we, obs_tag_way, obs_tag_set, obs_tag_wdata, obs_inv_wdata, t); end
        n_vec++; if (!obs_done || obs_done_hit !== 1'b0 || obs_done_way !== 2'd0) begin n_err++;
            $display("FAIL cold_resp: got done=%0d hit=%b way=%0d expected 1 0 0", obs_done, obs_done_hit, obs_done_way); end
        n_vec++; if (obs_cyc != WORDS + 4) begin n_err++; $display("FAIL cold_latency: got %0d expected %0d", obs_cyc, WORDS + 4); end
    endtask

    task automatic test_plru_sequence();
        int ev;
        for (int w = 0; w < 3; w++) begin
            run_txn(K'($urandom), 4'd1, 1'b1, 2'(w), 4'b0000, 0, 0, 0, 0);
            model_touch(1, w);
        end
        for (int r = 0; r < 2; r++) begin
            ev = model_victim(1, 4'b0000);
            run_txn(K'($urandom), 4'd1, 1'b0, 2'd0, 4'b0000, 0, 0, 0, 0);
            model_touch(1, ev);
            n_vec++; if (int'(obs_done_way) != ev || int'(obs_tag_way) != ev) begin n_err++;
                $display("FAIL plru_seq_%0d: got way=%0d expected %0d", r, obs_done_way, ev); end
        end
    endtask

    task automatic test_stalls();
        int ev;
        ev = model_victim(9, 4'b0100);
        run_txn(12'hBEE, 4'd9, 1'b0, 2'd0, 4'b0100, 5, 50, 1, 0);
        model_touch(9, ev);
        n_vec++; if (obs_req_cycles != 6 || obs_addr_changed || obs_addr !== {12'hBEE, 4'd9}) begin n_err++;
            $display("FAIL stall_req: got cycles=%0d changed=%0d addr=%h expected 6 0 %h", obs_req_cycles, obs_addr_changed, obs_addr, {12'hBEE, 4'd9}); end
        n_vec++; if (obs_stray_we) begin n_err++; $display("FAIL stray_data: got data_we outside FILL, expected none"); end
        n_vec++; if (obs_beats != WORDS || obs_word_err || obs_data_err) begin n_err++;
            $display("FAIL stall_beats: got beats=%0d worderr=%0d dataerr=%0d expected %0d 0 0", obs_beats, obs_word_err, obs_data_err, WORDS); end
        n_vec++; if (obs_tag_we != 1 || obs_tag_beats != WORDS || int'(obs_tag_way) != ev) begin n_err++;
            $display("FAIL stall_tagwr: got n=%0d after=%0d way=%0d expected 1 %0d %0d", obs_tag_we, obs_tag_beats, obs_tag_way, WORDS, ev); end
    endtask

    task automatic test_random();
        logic [K-1:0] t; logic [SB-1:0] s; logic h; logic [1:0] hw; logic [3:0] iv;
        int ev;
        for (int i = 0; i < 24; i++) begin
            t = K'($urandom); s = SB'($urandom_range(3)); h = ($urandom_range(2) == 0);
            hw = 2'($urandom); iv = ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom);
            ev = h ? int'(hw) : model_victim(int'(s), iv);
            run_txn(t, s, h, hw, iv, $urandom_range(3), $urandom_range(40), 1'($urandom), 0);
            model_touch(int'(s), ev);
            n_vec++;
            if (!obs_done || obs_done_hit !== h || int'(obs_done_way) != ev ||
                obs_tag_we != (h ? 0 : 1) || obs_beats != (h ? 0 : WORDS) || obs_word_err || obs_stray_we ||
                (!h && (obs_tag_wdata !== t || obs_tag_set !== s || int'(obs_tag_way) != ev || obs_addr !== {t, s}))) begin
                n_err++;
                $display("FAIL random_%0d: got done=%0d hit=%b way=%0d tagwe=%0d beats=%0d expected hit=%b way=%0d", i,
                         obs_done, obs_done_hit, obs_done_way, obs_tag_we, obs_beats, h, ev);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int tw;
        run_txn(12'h777, 4'd7, 1'b1, 2'd0, 4'b0000, 0, 0, 0, 0);
        model_touch(7, 0);
        run_txn(12'h3C3, 4'd7, 1'b0, 2'd0, 4'b0000, 0, 0, 0, 2);
        n_vec++; if ({mem_req, data_we, tag_we, done, done_hit, done_way, mem_addr} !== '0) begin n_err++;
            $display("FAIL abort_outputs: got req=%b we=%b twe=%b done=%b addr=%h expected all 0", mem_req, data_we, tag_we, done, mem_addr); end
        model_reset();
        @(negedge clk); mem_rvalid = 1'b0; rst_n = 1'b1;
        tw = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (tag_we || data_we) tw++;
        end
        n_vec++; if (tw != 0 || req_ready !== 1'b1) begin n_err++;
            $display("FAIL abort_release: got writes=%0d ready=%b expected 0 1", tw, req_ready); end
        run_txn(12'h3C3, 4'd7, 1'b0, 2'd0, 4'b0000, 0, 0, 0, 0);
        n_vec++; if (obs_done_way !== 2'(model_victim(7, 4'b0000))) begin n_err++;
            $display("FAIL abort_plru_cleared: got way=%0d expected %0d", obs_done_way, model_victim(7, 4'b0000)); end
        model_touch(7, model_victim(7, 4'b0000));
    endtask

    initial begin
        test_reset();
        test_hit();
        test_cold_miss();
        test_plru_sequence();
        test_stalls();
        test_random();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
